// File: rtl/midi_pkg.sv
// Shared MIDI types: event record, parser states and byte-class constants.
package midi_pkg;

    typedef enum logic [2:0] {
        EVT_NOTE_OFF = 3'd0,
        EVT_NOTE_ON  = 3'd1,
        EVT_POLY_AT  = 3'd2,
        EVT_CC       = 3'd3,
        EVT_PROG     = 3'd4,
        EVT_CHAN_AT  = 3'd5,
        EVT_PITCH    = 3'd6
    } evt_type_e;

    typedef struct packed {
        evt_type_e   evt_type;
        logic [3:0]  channel;
        logic [6:0]  data1;
        logic [6:0]  data2;
    } midi_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_D1,
        ST_WAIT_D2,
        ST_SYSEX
    } parse_state_e;

    localparam logic [7:0] SYSEX_START   = 8'hF0;
    localparam logic [7:0] SYSTEM_MIN    = 8'hF0;
    localparam logic [7:0] REALTIME_MIN  = 8'hF8;
    localparam logic [3:0] NIBBLE_PROG   = 4'hC;
    localparam logic [3:0] NIBBLE_CHANAT = 4'hD;

    // Program change and channel aftertouch carry a single data byte.
    function automatic logic is_one_data(input logic [3:0] status_hi);
        return (status_hi == NIBBLE_PROG) || (status_hi == NIBBLE_CHANAT);
    endfunction

endpackage

// File: rtl/midi_evt_fifo.sv
// Show-ahead synchronous FIFO of parsed MIDI events.
module midi_evt_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  midi_evt_t push_evt,
    input  logic      pop,
    output midi_evt_t head_evt,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    midi_evt_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_write;
    logic          do_read;

    // A write into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_write = push && (!full || pop);
    assign do_read  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Head is forced to zero when empty so the event outputs idle at 0.
    assign head_evt = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Event storage, no reset needed: contents are masked by empty.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= push_evt;
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice parser: running status, real-time passthrough, SysEx skip,
// channel filter, and an event FIFO with valid/ready output.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       cfg_omni,
    input  logic [3:0] cfg_channel,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_type,
    output logic [3:0] evt_channel,
    output logic [6:0] evt_data1,
    output logic [6:0] evt_data2,
    output logic       overflow
);

    parse_state_e state_q, state_d;
    logic [7:0]   status_q, status_d;
    logic [6:0]   d1_q, d1_d;
    logic         complete;
    logic [6:0]   cmp_d1;
    logic [6:0]   cmp_d2;
    logic         chan_ok;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    midi_evt_t    new_evt;
    midi_evt_t    head_evt;

    // Parser state and running status register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // First data byte holding register; only meaningful in WAIT_D2.
    always_ff @(posedge clk) begin
        d1_q <= d1_d;
    end

    // Byte classification, next-state and message completion.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        d1_d     = d1_q;
        complete = 1'b0;
        cmp_d1   = d1_q;
        cmp_d2   = '0;
        if (byte_valid) begin
            if (byte_in >= REALTIME_MIN) begin
                // Real-time bytes are transparent to message assembly.
            end else if (byte_in[7] && (byte_in < SYSTEM_MIN)) begin
                status_d = byte_in;
                state_d  = ST_WAIT_D1;
            end else if (byte_in == SYSEX_START) begin
                status_d = '0;
                state_d  = ST_SYSEX;
            end else if (byte_in[7]) begin
                status_d = '0;
                state_d  = ST_IDLE;
            end else begin
                case (state_q)
                    ST_WAIT_D1: begin
                        d1_d = byte_in[6:0];
                        if (is_one_data(status_q[7:4])) begin
                            complete = 1'b1;
                            cmp_d1   = byte_in[6:0];
                        end else begin
                            state_d = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        complete = 1'b1;
                        cmp_d2   = byte_in[6:0];
                        state_d  = ST_WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Event formatting; a zero-velocity note-on is reported as note-off.
    always_comb begin
        new_evt          = '0;
        new_evt.evt_type = evt_type_e'(status_q[6:4]);
        new_evt.channel  = status_q[3:0];
        new_evt.data1    = cmp_d1;
        new_evt.data2    = cmp_d2;
        if ((new_evt.evt_type == EVT_NOTE_ON) && (cmp_d2 == 7'd0)) begin
            new_evt.evt_type = EVT_NOTE_OFF;
        end
    end

    assign chan_ok = cfg_omni || (status_q[3:0] == cfg_channel);
    assign push    = complete && chan_ok;
    assign pop     = evt_valid && evt_ready;

    midi_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_evt (new_evt),
        .pop      (pop),
        .head_evt (head_evt),
        .full     (full),
        .empty    (empty)
    );

    // Registered drop indicator for an event that found the FIFO full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow <= 1'b0;
        else        overflow <= push && full && !pop;
    end

    assign evt_valid   = !empty;
    assign evt_type    = head_evt.evt_type;
    assign evt_channel = head_evt.channel;
    assign evt_data1   = head_evt.data1;
    assign evt_data2   = head_evt.data2;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser: directed vectors plus a random phase against a reference model.
module tb_midi_msg_parser;

    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       cfg_omni = 1'b1;
    logic [3:0] cfg_channel = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] evt_type;
    logic [3:0] evt_channel;
    logic [6:0] evt_data1;
    logic [6:0] evt_data2;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int cyc = 0;
    bit rnd_mode = 0;
    bit rdy_val = 1;

    logic [20:0] exp_q[$];

    // Reference model state: 0 idle, 1 wait d1, 2 wait d2, 3 sysex.
    int         m_state = 0;
    logic [7:0] m_status = '0;
    logic [6:0] m_d1 = '0;

    midi_msg_parser #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .cfg_omni    (cfg_omni),
        .cfg_channel (cfg_channel),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_type    (evt_type),
        .evt_channel (evt_channel),
        .evt_data1   (evt_data1),
        .evt_data2   (evt_data2),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Ready driver: forced value, or a pattern that is low at most one cycle in three.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rnd_mode) evt_ready = !((cyc % 3 == 0) && ($urandom_range(0, 1) == 1));
            else          evt_ready = rdy_val;
        end
    end

    // Monitor: every accepted head is compared against the scoreboard.
    initial begin
        logic [20:0] got;
        logic [20:0] exp;
        forever begin
            @(negedge clk);
            if (overflow) ovf_cnt++;
            if (evt_valid && evt_ready) begin
                got = {evt_type, evt_channel, evt_data1, evt_data2};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got=%h expected none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL event got type=%0d ch=%0d d1=%h d2=%h required type=%0d ch=%0d d1=%h d2=%h",
                                 got[20:18], got[17:14], got[13:7], got[6:0],
                                 exp[20:18], exp[17:14], exp[13:7], exp[6:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [2:0] t, input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2);
        exp_q.push_back({t, ch, d1, d2});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && (exp_q.size() != 0 || evt_valid); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_idle"}, {31'd0, evt_valid}, 0);
    endtask

    task automatic model_emit(input logic [6:0] d1, input logic [6:0] d2);
        logic [2:0] t;
        t = m_status[6:4];
        if (t == 3'd1 && d2 == 7'd0) t = 3'd0;
        if (cfg_omni || m_status[3:0] == cfg_channel) expect_evt(t, m_status[3:0], d1, d2);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'hF8) return;
        if (b >= 8'h80 && b <= 8'hEF) begin
            m_status = b;
            m_state  = 1;
        end else if (b == 8'hF0) begin
            m_state = 3;
        end else if (b >= 8'hF1) begin
            m_state = 0;
        end else if (m_state == 1) begin
            m_d1 = b[6:0];
            if (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) model_emit(m_d1, 7'd0);
            else m_state = 2;
        end else if (m_state == 2) begin
            model_emit(m_d1, b[6:0]);
            m_state = 1;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 28)      return 8'($urandom_range(8'h80, 8'hEF));
        else if (r < 34) return 8'($urandom_range(8'hF0, 8'hFF));
        else             return 8'($urandom_range(0, 8'h7F));
    endfunction

    initial begin
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, evt_valid}, 0);
        check("rst_fields", {14'd0, evt_type, evt_channel, evt_data1, evt_data2}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        reset = 1'b1;
        rdy_val = 1'b1;
        repeat (2) @(posedge clk);

        // 1: single note-on with latency check
        expect_evt(3'd1, 4'd0, 7'h3C, 7'h64);
        send(8'h90); send(8'h3C); send(8'h64);
        check("t1_latency_valid", {31'd0, evt_valid}, 1);
        wait_drain("t1");

        // 2: running status, zero velocity becomes note-off
        expect_evt(3'd1, 4'd1, 7'h3C, 7'h64);
        expect_evt(3'd0, 4'd1, 7'h40, 7'h00);
        send(8'h91); send(8'h3C); send(8'h64); send(8'h40); send(8'h00);
        wait_drain("t2");

        // 3: CC with interleaved clock, then program change with running status
        expect_evt(3'd3, 4'd2, 7'h07, 7'h7F);
        expect_evt(3'd4, 4'd5, 7'h0A, 7'h00);
        expect_evt(3'd4, 4'd5, 7'h0B, 7'h00);
        send(8'hB2); send(8'h07); send(8'hF8); send(8'h7F);
        send(8'hC5); send(8'h0A); send(8'h0B);
        wait_drain("t3");

        // 4: SysEx skipped, SysEx aborts a partial message
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
        wait_drain("t4");

        // 5a: channel filter
        cfg_omni = 1'b0;
        cfg_channel = 4'd3;
        expect_evt(3'd1, 4'd3, 7'h10, 7'h20);
        send(8'h93); send(8'h10); send(8'h20);
        send(8'h94); send(8'h10); send(8'h20);
        wait_drain("t5a");

        // 5b: overflow with consumer stalled
        rdy_val = 1'b0;
        repeat (2) @(posedge clk);
        ovf_cnt = 0;
        send(8'h93);
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            if (i < FIFO_DEPTH) expect_evt(3'd1, 4'd3, 7'(i + 1), 7'h20);
            send(8'(i + 1)); send(8'h20);
        end
        repeat (3) @(posedge clk);
        #1;
        check("t5_overflow_pulses", ovf_cnt, 1);
        check("t5_head_held_valid", {31'd0, evt_valid}, 1);
        check("t5_head_held_data1", {25'd0, evt_data1}, 1);
        rdy_val = 1'b1;
        wait_drain("t5b");
        cfg_omni = 1'b1;

        // 6: reset mid-message loses the partial message
        send(8'h90); send(8'h3C);
        #3;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, evt_valid}, 0);
        check("t6_rst_fields", {14'd0, evt_type, evt_channel, evt_data1, evt_data2}, 0);
        check("t6_rst_overflow", {31'd0, overflow}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(8'h40);
        wait_drain("t6_after_reset");

        // Random bytes against the reference model, omni then filtered
        m_state = 0;
        m_status = '0;
        ovf_cnt = 0;
        rnd_mode = 1;
        for (int k = 0; k < 500; k++) begin
            if (k == 250) begin
                cfg_omni = 1'b0;
                cfg_channel = 4'd5;
            end
            b = rand_byte();
            model_byte(b);
            send(b);
            @(posedge clk);
        end
        wait_drain("rand");
        check("rand_no_overflow", ovf_cnt, 0);
        rnd_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
